// File: rtl/game_pkg.sv
// Shared types and constants for the lane dodge game: FSM encoding,
// spawn LFSR shape and score width.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    LOST    = 2'd2,
    CLEARED = 2'd3
  } game_state_t;

  localparam int LFSR_W = 8;
  // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam int SCORE_W = 8;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/key_pulse.sv
// Button conditioning: two-flop synchroniser followed by a registered
// rising-edge detector, giving one clean pulse per press.
module key_pulse (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic pulse
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/lane_dodge_game.sv
// Lane dodge game: obstacles scroll toward the player column, the player
// switches lanes with up/down, and the field is multiplexed onto a scanned display.
module lane_dodge_game
  import game_pkg::*;
#(
  parameter int                NUM_DIGITS  = 8,
  parameter int                NUM_LANES   = 3,
  parameter int                TICK_DIV    = 1_000_000,
  parameter int                SCAN_DIV    = 1_000,
  parameter int                CLEAR_SCORE = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_up,
  input  logic                  key_down,
  input  logic                  key_star,
  output logic [NUM_LANES-1:0]  seg_lane,
  output logic [NUM_DIGITS-1:0] com,
  output logic [SCORE_W-1:0]    score,
  output logic [1:0]            game_state,
  output logic                  LED_RED,
  output logic                  LED_GREEN
);

  localparam int LANE_W  = (NUM_LANES  > 1) ? $clog2(NUM_LANES)  : 1;
  localparam int DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TICK_W  = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int SCAN_W  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;

  game_state_t state, next_state;

  logic                 up_p, down_p, star_p;
  logic [LANE_W-1:0]    player;
  logic [NUM_LANES-1:0] field [NUM_DIGITS];
  logic [NUM_LANES-1:0] player_oh, spawn_pat;
  logic [LFSR_W-1:0]    lfsr;
  logic [6:0]           spawn_idx;
  logic [TICK_W-1:0]    tick_cnt;
  logic [SCAN_W-1:0]    scan_cnt;
  logic [DIGIT_W-1:0]   digit;
  logic                 tick_wrap, collision, enter_idle;

  key_pulse u_key_up   (.clk(clk), .rst(rst), .key(key_up),   .pulse(up_p));
  key_pulse u_key_down (.clk(clk), .rst(rst), .key(key_down), .pulse(down_p));
  key_pulse u_key_star (.clk(clk), .rst(rst), .key(key_star), .pulse(star_p));

  // The top column still holds the previous spawn, which keeps obstacles at least two columns apart
  assign player_oh  = NUM_LANES'(1) << player;
  assign spawn_idx  = 7'(lfsr[LFSR_W-1:1] % 7'(NUM_LANES));
  assign spawn_pat  = (lfsr[0] && field[NUM_DIGITS-1] == '0) ? (NUM_LANES'(1) << spawn_idx) : '0;
  assign collision  = |(field[0] & player_oh);
  assign tick_wrap  = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign enter_idle = (state == LOST || state == CLEARED) && star_p;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Collision is tested before the clear condition so a loss always wins
  always_comb begin
    next_state = state;
    game_state = state;
    LED_RED    = 1'b0;
    LED_GREEN  = 1'b0;
    case (state)
      IDLE:          if (star_p) next_state = RUN;
      RUN: begin
        if (collision)                              next_state = LOST;
        else if (score == SCORE_W'(CLEAR_SCORE))    next_state = CLEARED;
      end
      LOST, CLEARED: if (star_p) next_state = IDLE;
      default:       next_state = IDLE;
    endcase
    LED_RED   = (state == LOST);
    LED_GREEN = (state == CLEARED);
  end

  always_ff @(posedge clk) begin
    if (rst || enter_idle) begin
      score    <= '0;
      player   <= LANE_W'(NUM_LANES / 2);
      tick_cnt <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) field[i] <= '0;
      if (rst) lfsr <= LFSR_SEED;
    end else if (state == RUN) begin
      if (up_p && !down_p) begin
        if (player != '0) player <= player - LANE_W'(1);
      end else if (down_p && !up_p) begin
        if (player != LANE_W'(NUM_LANES - 1)) player <= player + LANE_W'(1);
      end

      if (tick_wrap) begin
        tick_cnt <= '0;
        for (int i = 0; i < NUM_DIGITS - 1; i++) field[i] <= field[i+1];
        field[NUM_DIGITS-1] <= spawn_pat;
        lfsr <= lfsr_step(lfsr);
        if (field[0] != '0 && !collision) score <= score + SCORE_W'(1);
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  // Display outputs are registered from the current digit, so they trail it by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= '0;
      com      <= '1;
      seg_lane <= '0;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        digit    <= (digit == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : digit + DIGIT_W'(1);
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      com      <= ~(NUM_DIGITS'(1) << digit);
      seg_lane <= field[digit] | ((digit == '0 && state != IDLE) ? player_oh : '0);
    end
  end

endmodule

// File: tb/tb_lane_dodge_game.sv
// Directed self-checking bench for lane_dodge_game with a small 4-digit, 3-lane field.
// Obstacle timing follows the seed-A5 spawn sequence: lane1, -, lane2, -, -, lane0, -, lane2, -, lane0.
module tb_lane_dodge_game;

  logic       clk = 1'b0;
  logic       rst, key_up, key_down, key_star;
  logic [2:0] seg_lane;
  logic [3:0] com;
  logic [7:0] score;
  logic [1:0] game_state;
  logic       LED_RED, LED_GREEN;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lane_dodge_game #(
    .NUM_DIGITS(4), .NUM_LANES(3), .TICK_DIV(4), .SCAN_DIV(2),
    .CLEAR_SCORE(3), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .key_star(key_star),
    .seg_lane(seg_lane), .com(com), .score(score), .game_state(game_state),
    .LED_RED(LED_RED), .LED_GREEN(LED_GREEN)
  );

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; key_up = 1'b0; key_down = 1'b0; key_star = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // Returns one negedge after the edge that moves the FSM into RUN
  task automatic start_game;
    key_star = 1'b1;
    step(1);
    key_star = 1'b0;
    step(3);
  endtask

  task automatic read_digit0(output logic [2:0] seg);
    bit found = 1'b0;
    seg = 'x;
    for (int i = 0; i < 12 && !found; i++) begin
      if (com === 4'b1110) begin
        seg = seg_lane;
        found = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("[TB] FAIL digit0_scan: com=%b never reached required 1110", com);
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_com;
    do_reset;
    n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("[TB] FAIL reset_state: got %0d want 0", game_state); end
    n_cmp++; if (score !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_score: got %0d want 0", score); end
    n_cmp++; if ({LED_RED, LED_GREEN} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_leds: got %b want 00", {LED_RED, LED_GREEN}); end
    n_cmp++; if (com !== 4'b1111) begin n_bad++; $display("[TB] FAIL reset_com: got %b want 1111", com); end
    n_cmp++; if (seg_lane !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_seg: got %b want 000", seg_lane); end
    for (int k = 1; k <= 20; k++) begin
      step(1);
      exp_com = ~(4'b0001 << (((k - 1) / 2) % 4));
      n_cmp++;
      if (com !== exp_com) begin n_bad++; $display("[TB] FAIL scan_com cycle %0d: got %b want %b", k, com, exp_com); end
    end
    n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("[TB] FAIL idle_hold_state: got %0d want 0", game_state); end
    n_cmp++; if (score !== 8'd0) begin n_bad++; $display("[TB] FAIL idle_hold_score: got %0d want 0", score); end
    n_cmp++; if ({LED_RED, LED_GREEN} !== 2'b00) begin n_bad++; $display("[TB] FAIL idle_hold_leds: got %b want 00", {LED_RED, LED_GREEN}); end
  endtask

  task automatic test_player_move;
    logic [2:0] seg;
    do_reset;
    key_star = 1'b1;
    step(1);
    key_star = 1'b0; key_up = 1'b1;
    step(1);
    key_up = 1'b0;
    step(1);
    key_up = 1'b1;
    step(1);
    key_up = 1'b0;
    n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("[TB] FAIL start_run: got %0d want 1", game_state); end
    step(1);
    key_up = 1'b1;
    step(1);
    key_up = 1'b0;
    step(3);
    read_digit0(seg);
    n_cmp++; if (seg !== 3'b001) begin n_bad++; $display("[TB] FAIL up_saturate: digit0 seg got %b want 001", seg); end
    key_up = 1'b1; key_down = 1'b1;
    step(1);
    key_up = 1'b0; key_down = 1'b0;
    step(4);
    read_digit0(seg);
    n_cmp++; if (seg[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL up_down_same: player bit got %b want 1", seg[0]); end
    n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("[TB] FAIL move_still_run: got %0d want 1", game_state); end
  endtask

  task automatic test_collision;
    do_reset;
    start_game;
    step(16);
    n_cmp++; if (LED_RED !== 1'b0) begin n_bad++; $display("[TB] FAIL hit_enter_red: got %b want 0", LED_RED); end
    n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("[TB] FAIL hit_enter_state: got %0d want 1", game_state); end
    step(1);
    n_cmp++; if (LED_RED !== 1'b1) begin n_bad++; $display("[TB] FAIL hit_red: got %b want 1", LED_RED); end
    n_cmp++; if (game_state !== 2'd2) begin n_bad++; $display("[TB] FAIL hit_state: got %0d want 2", game_state); end
    n_cmp++; if (score !== 8'd0) begin n_bad++; $display("[TB] FAIL hit_score: got %0d want 0", score); end
    step(8);
    n_cmp++; if (score !== 8'd0) begin n_bad++; $display("[TB] FAIL lost_score_frozen: got %0d want 0", score); end
    n_cmp++; if (game_state !== 2'd2) begin n_bad++; $display("[TB] FAIL lost_hold: got %0d want 2", game_state); end
    n_cmp++; if (LED_GREEN !== 1'b0) begin n_bad++; $display("[TB] FAIL lost_green: got %b want 0", LED_GREEN); end
  endtask

  task automatic test_clear;
    do_reset;
    start_game;
    key_up = 1'b1;
    step(1);
    key_up = 1'b0;
    step(28);
    key_down = 1'b1;
    step(1);
    key_down = 1'b0;
    n_cmp++; if (score !== 8'd2) begin n_bad++; $display("[TB] FAIL dodge_two: got %0d want 2", score); end
    step(10);
    n_cmp++; if (score !== 8'd3) begin n_bad++; $display("[TB] FAIL dodge_three: got %0d want 3", score); end
    n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("[TB] FAIL clear_pending: got %0d want 1", game_state); end
    step(1);
    n_cmp++; if (game_state !== 2'd3) begin n_bad++; $display("[TB] FAIL cleared_state: got %0d want 3", game_state); end
    n_cmp++; if ({LED_RED, LED_GREEN} !== 2'b01) begin n_bad++; $display("[TB] FAIL cleared_leds: got %b want 01", {LED_RED, LED_GREEN}); end
    key_star = 1'b1;
    step(1);
    key_star = 1'b0;
    step(3);
    n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("[TB] FAIL restart_idle: got %0d want 0", game_state); end
    n_cmp++; if (score !== 8'd0) begin n_bad++; $display("[TB] FAIL restart_score: got %0d want 0", score); end
    n_cmp++; if (LED_GREEN !== 1'b0) begin n_bad++; $display("[TB] FAIL restart_green: got %b want 0", LED_GREEN); end
    step(1);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (seg_lane !== 3'b000) begin n_bad++; $display("[TB] FAIL field_cleared com=%b: got %b want 000", com, seg_lane); end
      step(1);
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    start_game;
    key_up = 1'b1;
    step(1);
    key_up = 1'b0;
    step(35);
    n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("[TB] FAIL third_enter_state: got %0d want 1", game_state); end
    n_cmp++; if (score !== 8'd2) begin n_bad++; $display("[TB] FAIL third_enter_score: got %0d want 2", score); end
    step(1);
    n_cmp++; if (game_state !== 2'd2) begin n_bad++; $display("[TB] FAIL lost_wins_state: got %0d want 2", game_state); end
    n_cmp++; if ({LED_RED, LED_GREEN} !== 2'b10) begin n_bad++; $display("[TB] FAIL lost_wins_leds: got %b want 10", {LED_RED, LED_GREEN}); end
    step(4);
    n_cmp++; if (score !== 8'd2) begin n_bad++; $display("[TB] FAIL lost_wins_score: got %0d want 2", score); end
    n_cmp++; if (game_state !== 2'd2) begin n_bad++; $display("[TB] FAIL lost_wins_hold: got %0d want 2", game_state); end
  endtask

  task automatic test_reset_mid_game;
    bit seg_ok;
    do_reset;
    start_game;
    step(10);
    rst = 1'b1; key_star = 1'b1;
    step(1);
    n_cmp++; if (game_state !== 2'd0) begin n_bad++; $display("[TB] FAIL midrst_state: got %0d want 0", game_state); end
    n_cmp++; if (score !== 8'd0) begin n_bad++; $display("[TB] FAIL midrst_score: got %0d want 0", score); end
    n_cmp++; if (com !== 4'b1111) begin n_bad++; $display("[TB] FAIL midrst_com: got %b want 1111", com); end
    n_cmp++; if (seg_lane !== 3'b000) begin n_bad++; $display("[TB] FAIL midrst_seg: got %b want 000", seg_lane); end
    n_cmp++; if ({LED_RED, LED_GREEN} !== 2'b00) begin n_bad++; $display("[TB] FAIL midrst_leds: got %b want 00", {LED_RED, LED_GREEN}); end
    key_star = 1'b0;
    step(1);
    rst = 1'b0;
    seg_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (seg_lane !== 3'b000) seg_ok = 1'b0;
    end
    n_cmp++; if (!seg_ok) begin n_bad++; $display("[TB] FAIL midrst_field: seg got %b want 000 in every digit", seg_lane); end
    start_game;
    step(16);
    n_cmp++; if (game_state !== 2'd1) begin n_bad++; $display("[TB] FAIL midrst_replay_run: got %0d want 1", game_state); end
    step(1);
    n_cmp++; if (LED_RED !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_replay_hit: got %b want 1", LED_RED); end
  endtask

  initial begin
    test_reset;
    test_player_move;
    test_collision;
    test_clear;
    test_back_to_back;
    test_reset_mid_game;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lane_dodge_game.md
LANE_DODGE_GAME -- requirements
Module: lane_dodge_game

Interface
REQ-001 Parameter NUM_DIGITS, default 8, count of display columns; column 0 is the player column.
REQ-002 Parameter NUM_LANES, default 3, count of lanes (2..7); lane 0 is the top segment.
REQ-003 Parameter TICK_DIV, default 1_000_000, clock cycles per obstacle shift step.
REQ-004 Parameter SCAN_DIV, default 1_000, clock cycles per display digit slot.
REQ-005 Parameter CLEAR_SCORE, default 16, passed obstacles required to clear (1..255).
REQ-006 Parameter LFSR_SEED, default 8'hA5, nonzero spawn LFSR reset value.
REQ-007 The design SHALL have one clock and a synchronous, active-high reset.
REQ-008 Port clk, input, 1, system clock.
REQ-009 Port rst, input, 1, synchronous active-high reset.
REQ-010 Ports key_up, key_down, key_star, input, 1 each, asynchronous active-high buttons.
REQ-011 Port seg_lane, output, NUM_LANES, active-high lane segments for the scanned digit.
REQ-012 Port com, output, NUM_DIGITS, active-low one-hot digit enable.
REQ-013 Port score, output, 8, obstacles passed in the current game.
REQ-014 Port game_state, output, 2, encoding: IDLE=0, RUN=1, LOST=2, CLEARED=3.
REQ-015 Ports LED_RED and LED_GREEN, output, 1 each, lost and cleared indicators.

Function
REQ-016 Each key SHALL pass a 2-flop synchroniser and rising-edge detector: one 1-cycle pulse per press, 3 cycles after the input rises.
REQ-017 FSM: IDLE -star-> RUN; RUN -collision-> LOST; RUN -score==CLEAR_SCORE-> CLEARED; LOST or CLEARED -star-> IDLE.
REQ-018 Entering IDLE SHALL clear the field, score, and tick counter, and set the player to lane NUM_LANES/2.
REQ-019 In RUN, an up pulse SHALL decrement the lane (saturate at 0); a down pulse SHALL increment it (saturate at NUM_LANES-1); simultaneous pulses SHALL leave it unchanged.
REQ-020 In RUN, the tick counter SHALL count 0..TICK_DIV-1 and wrap; on wrap, the field SHALL shift one column toward column 0 and the top column SHALL load the spawn pattern.
REQ-021 Spawn: the 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL advance each step; if lfsr[0]=1 and the previous spawn was empty, spawn one-hot lane (lfsr[7:1] mod NUM_LANES); otherwise spawn empty.
REQ-022 On a shift, if column 0 was nonzero and no collision occurred, score SHALL increment by 1 on the same edge.
REQ-023 Collision SHALL be (column0 AND player one-hot)!=0, evaluated every RUN cycle on the registered values; it SHALL cause LOST on the next edge.
REQ-024 If a collision and score reaching CLEAR_SCORE occur in the same cycle, LOST SHALL win.
REQ-025 Outside RUN, the field, player, score and LFSR SHALL hold; key up/down pulses SHALL be ignored.
REQ-026 The scan SHALL advance the digit every SCAN_DIV cycles, wrapping from NUM_DIGITS-1 to 0, in all states.
REQ-027 com and seg_lane SHALL be registered; seg_lane = column bits, OR'd with the player one-hot on digit 0 in RUN/LOST/CLEARED.
REQ-028 LED_RED SHALL be 1 exactly in LOST; LED_GREEN SHALL be 1 exactly in CLEARED.

Reset
REQ-029 Reset SHALL give: state IDLE, score 0, field 0, player NUM_LANES/2, LFSR LFSR_SEED, counters 0, com all-ones, seg_lane 0, LEDs 0, synchroniser flops 0.
REQ-030 Reset asserted mid-game SHALL take priority over every other event on that edge.

Structure
REQ-031 Package game_pkg SHALL hold the state enum, the LFSR width/taps constant, and the score width.
REQ-032 Sub-module key_pulse (synchroniser plus edge detect) SHALL be instantiated three times; the rest stays flat.

Verification (bench params: NUM_DIGITS=4, NUM_LANES=3, TICK_DIV=4, SCAN_DIV=2, CLEAR_SCORE=3)
REQ-033 Reset, then hold 20 cycles -> state=0, score=0, LEDs 0; com cycles 1110,1101,1011,0111, each for 2 cycles.
REQ-034 star pulse, then up x3 -> state=1, player lane 0 (saturated); up+down in the same cycle -> lane unchanged.
REQ-035 Force spawn in lane 1 with player on lane 1 -> LED_RED=1 one cycle after the obstacle enters column 0; score frozen.
REQ-036 Dodge 3 obstacles -> score=3, state=3, LED_GREEN=1; star -> state=0, field cleared, score=0.
REQ-037 Collision on the same edge score reaches 3 -> state=2, not 3.
REQ-038 rst during RUN with a nonzero field -> all REQ-029 values on the next edge.
